// File: rtl/spi_master.sv
// SPI mode-0 master: one MSB-first byte per start request, with optional
// slave-select hold so consecutive bytes can share a single ss-low frame.
//
// Ports:
//   clk      system clock (rising edge)
//   rst_n    asynchronous active-low reset
//   start    transfer request, sampled only while busy = 0
//   hold_ss  sampled with start; 1 keeps ss low after the byte completes
//   din      byte to transmit, MSB first
//   dout     last received byte
//   busy     transfer in progress
//   done     one-cycle pulse when dout updates
//   ss       slave select, active-low
//   sck      serial clock, idles low
//   mosi     serial data out (changes only while sck is low)
//   miso     serial data in (sampled on sck rising edges)
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold_ss,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       ss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TOG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [TOG_W-1:0]   tog_cnt_q, tog_cnt_d;
    logic [6:0]         tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic               hold_q, hold_d;
    logic [7:0]         dout_d;
    logic               busy_d, done_d, ss_d, sck_d, mosi_d;

    logic               phase_end_c;
    logic               last_tog_c;

    assign phase_end_c = (div_cnt_q == CNT_W'(CLK_DIV - 1));
    assign last_tog_c  = (tog_cnt_q == {TOG_W{1'b1}});

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            tog_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            hold_q    <= 1'b0;
            dout      <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            ss        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            tog_cnt_q <= tog_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            hold_q    <= hold_d;
            dout      <= dout_d;
            busy      <= busy_d;
            done      <= done_d;
            ss        <= ss_d;
            sck       <= sck_d;
            mosi      <= mosi_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (phase_end_c) state_d = XFER;
            XFER:    if (phase_end_c && last_tog_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        div_cnt_d = div_cnt_q;
        tog_cnt_d = tog_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        hold_d    = hold_q;
        dout_d    = dout;
        busy_d    = busy;
        done_d    = 1'b0;
        ss_d      = ss;
        sck_d     = sck;
        mosi_d    = mosi;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                tog_cnt_d = '0;
                if (start) begin
                    // ss may already be low from a held frame; driving 0 again keeps it glitch-free
                    tx_d   = din[6:0];
                    hold_d = hold_ss;
                    ss_d   = 1'b0;
                    mosi_d = din[7];
                    busy_d = 1'b1;
                end
            end

            SETUP: begin
                div_cnt_d = phase_end_c ? '0 : div_cnt_q + CNT_W'(1);
            end

            XFER: begin
                if (phase_end_c) begin
                    div_cnt_d = '0;
                    sck_d     = ~sck;
                    tog_cnt_d = tog_cnt_q + TOG_W'(1);
                    if (!sck) begin
                        rx_d = {rx_q[6:0], miso};
                    end else if (!last_tog_c) begin
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[5:0], 1'b0};
                    end
                    // 16th toggle is the 8th falling edge: finish and keep mosi as is
                    if (last_tog_c) begin
                        tog_cnt_d = '0;
                        dout_d    = rx_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        ss_d      = ~hold_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                div_cnt_d = '0;
                tog_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: loopback at CLK_DIV=2 and 255, a shifting
// slave model at CLK_DIV=4 for held frames, ignored starts and reset abort.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT at CLK_DIV=4 with slave model
    logic       start4 = 1'b0, hold4 = 1'b0, miso4;
    logic [7:0] din4 = 8'h00, dout4;
    logic       busy4, done4, ss4, sck4, mosi4;

    spi_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .hold_ss(hold4), .din(din4),
        .dout(dout4), .busy(busy4), .done(done4), .ss(ss4), .sck(sck4),
        .mosi(mosi4), .miso(miso4)
    );

    // DUT at CLK_DIV=2, loopback
    logic       start2 = 1'b0, hold2 = 1'b0;
    logic [7:0] din2 = 8'h00, dout2;
    logic       busy2, done2, ss2, sck2, mosi2;

    spi_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .hold_ss(hold2), .din(din2),
        .dout(dout2), .busy(busy2), .done(done2), .ss(ss2), .sck(sck2),
        .mosi(mosi2), .miso(mosi2)
    );

    // DUT at CLK_DIV=255, loopback
    logic       start9 = 1'b0, hold9 = 1'b0;
    logic [7:0] din9 = 8'h00, dout9;
    logic       busy9, done9, ss9, sck9, mosi9;

    spi_master #(.CLK_DIV(255)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .hold_ss(hold9), .din(din9),
        .dout(dout9), .busy(busy9), .done(done9), .ss(ss9), .sck(sck9),
        .mosi(mosi9), .miso(mosi9)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];   // expected dout per transfer
    logic [7:0] expm_q[$];  // expected byte seen on mosi per transfer

    // Slave model: presents slv_sh[7] on miso, captures mosi on sck rising edges
    logic [7:0] slv_sh = 8'h00, slv_next = 8'h00, mrx = 8'h00, last_mosi = 8'h00;
    int         slv_n = 0;
    assign miso4 = slv_sh[7];

    always @(posedge sck4) begin
        mrx = {mrx[6:0], mosi4};
        if (slv_n == 7) begin
            slv_n     = 0;
            last_mosi = mrx;
            slv_sh    = slv_next;
        end else begin
            slv_n++;
            slv_sh = {slv_sh[6:0], 1'b0};
        end
    end

    int rise4 = 0, rise2 = 0, done_cnt4 = 0;
    always @(posedge sck4) rise4++;
    always @(posedge sck2) rise2++;
    always @(negedge clk) if (done4) done_cnt4++;

    int   acc_cyc, first_rise, mosi_lo, ss_hi;
    logic sck_prev;

    task automatic slave_prime(input logic [7:0] b);
        slv_sh = b;
        slv_n  = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic go4(input logic [7:0] d, input logic h);
        start4 = 1'b1;
        din4   = d;
        hold4  = h;
        @(negedge clk);
        acc_cyc    = cyc;
        start4     = 1'b0;
        din4       = ~d;
        hold4      = ~h;
        first_rise = -1;
        mosi_lo    = mosi4 ? 0 : 1;
        ss_hi      = 0;
        sck_prev   = sck4;
    endtask

    task automatic wait_done4(input int budget, output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sck4 && !sck_prev && first_rise < 0) first_rise = cyc;
            sck_prev = sck4;
            if (!mosi4) mosi_lo++;
            if (ss4 && !done4) ss_hi++;
            if (done4) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ss4, sck4, mosi4, busy4, done4, dout4} !== {5'b10000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_dut4 got %b exp %b", {ss4, sck4, mosi4, busy4, done4, dout4}, {5'b10000, 8'h00});
        end
        n_vec++;
        if ({ss2, sck2, busy2, done2, ss9, sck9, busy9, done9} !== 8'b1000_1000) begin
            n_err++;
            $display("FAIL reset_dut2_9 got %b exp 10001000", {ss2, sck2, busy2, done2, ss9, sck9, busy9, done9});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_div2;
        int  a, lat;
        bit  tmo;
        logic [7:0] e;
        rise2  = 0;
        start2 = 1'b1; din2 = 8'hA5; hold2 = 1'b0;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        a = cyc; start2 = 1'b0; din2 = 8'h00;
        tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done2) begin tmo = 1'b0; break; end
        end
        lat = cyc - a;
        e = exp_q.pop_front();
        n_vec++;
        if (tmo) begin n_err++; $display("FAIL div2_timeout no done within 100 cycles"); end
        n_vec++;
        if (lat !== 34) begin n_err++; $display("FAIL div2_latency got %0d exp 34", lat); end
        n_vec++;
        if (dout2 !== e) begin n_err++; $display("FAIL div2_dout got %h exp %h", dout2, e); end
        n_vec++;
        if (ss2 !== 1'b1 || busy2 !== 1'b0) begin
            n_err++; $display("FAIL div2_ss_busy got ss=%b busy=%b exp ss=1 busy=0", ss2, busy2);
        end
        n_vec++;
        if (rise2 !== 8) begin n_err++; $display("FAIL div2_sck_rises got %0d exp 8", rise2); end
        @(negedge clk);
    endtask

    task automatic test_slave_model;
        bit tmo;
        logic [7:0] e, em;
        slave_prime(8'h3C);
        slv_next = 8'h00;
        exp_q.push_back(8'h3C);
        expm_q.push_back(8'hFF);
        go4(8'hFF, 1'b0);
        wait_done4(200, tmo);
        e = exp_q.pop_front();
        em = expm_q.pop_front();
        n_vec++;
        if (tmo) begin n_err++; $display("FAIL model_timeout no done within 200 cycles"); end
        n_vec++;
        if (cyc - acc_cyc !== 68) begin n_err++; $display("FAIL model_latency got %0d exp 68", cyc - acc_cyc); end
        n_vec++;
        if (dout4 !== e) begin n_err++; $display("FAIL model_dout got %h exp %h", dout4, e); end
        n_vec++;
        if (last_mosi !== em) begin n_err++; $display("FAIL model_mosi_byte got %h exp %h", last_mosi, em); end
        n_vec++;
        if (mosi_lo !== 0) begin n_err++; $display("FAIL model_mosi_high got %0d low samples exp 0", mosi_lo); end
        n_vec++;
        if (first_rise - acc_cyc !== 8) begin
            n_err++; $display("FAIL model_first_rise got %0d exp 8", first_rise - acc_cyc);
        end
        n_vec++;
        if (ss4 !== 1'b1 || busy4 !== 1'b0) begin
            n_err++; $display("FAIL model_end_ss_busy got ss=%b busy=%b exp ss=1 busy=0", ss4, busy4);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit tmo;
        int ss_hi1;
        logic [7:0] e, em;
        slave_prime(8'h81);
        slv_next = 8'h7E;
        exp_q.push_back(8'h81);  expm_q.push_back(8'h12);
        go4(8'h12, 1'b1);
        wait_done4(200, tmo);
        ss_hi1 = ss_hi;
        e = exp_q.pop_front(); em = expm_q.pop_front();
        n_vec++;
        if (tmo || dout4 !== e || last_mosi !== em) begin
            n_err++; $display("FAIL b2b_first got tmo=%b dout=%h mosi=%h exp tmo=0 dout=%h mosi=%h", tmo, dout4, last_mosi, e, em);
        end
        n_vec++;
        if (ss4 !== 1'b0 || busy4 !== 1'b0) begin
            n_err++; $display("FAIL b2b_first_end got ss=%b busy=%b exp ss=0 busy=0", ss4, busy4);
        end
        // Second start in the done cycle
        exp_q.push_back(8'h7E);  expm_q.push_back(8'h34);
        go4(8'h34, 1'b0);
        n_vec++;
        if (busy4 !== 1'b1 || ss4 !== 1'b0 || done4 !== 1'b0) begin
            n_err++; $display("FAIL b2b_second_accept got busy=%b ss=%b done=%b exp 1 0 0", busy4, ss4, done4);
        end
        slv_next = 8'h00;
        wait_done4(200, tmo);
        e = exp_q.pop_front(); em = expm_q.pop_front();
        n_vec++;
        if (tmo || cyc - acc_cyc !== 68) begin
            n_err++; $display("FAIL b2b_second_latency got tmo=%b lat=%0d exp tmo=0 lat=68", tmo, cyc - acc_cyc);
        end
        n_vec++;
        if (dout4 !== e || last_mosi !== em) begin
            n_err++; $display("FAIL b2b_second_data got dout=%h mosi=%h exp dout=%h mosi=%h", dout4, last_mosi, e, em);
        end
        n_vec++;
        if (ss_hi1 + ss_hi !== 0) begin
            n_err++; $display("FAIL b2b_ss_continuous got %0d high samples exp 0", ss_hi1 + ss_hi);
        end
        n_vec++;
        if (ss4 !== 1'b1) begin n_err++; $display("FAIL b2b_ss_release got %b exp 1", ss4); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy_start;
        bit tmo;
        int d0;
        logic [7:0] e, em;
        slave_prime(8'h69);
        slv_next = 8'h00;
        d0 = done_cnt4;
        exp_q.push_back(8'h69);  expm_q.push_back(8'hC5);
        go4(8'hC5, 1'b0);
        repeat (9) @(negedge clk);
        start4 = 1'b1; din4 = 8'h00;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(200, tmo);
        e = exp_q.pop_front(); em = expm_q.pop_front();
        n_vec++;
        if (tmo || cyc - acc_cyc !== 68) begin
            n_err++; $display("FAIL ignore_latency got tmo=%b lat=%0d exp tmo=0 lat=68", tmo, cyc - acc_cyc);
        end
        n_vec++;
        if (dout4 !== e || last_mosi !== em) begin
            n_err++; $display("FAIL ignore_data got dout=%h mosi=%h exp dout=%h mosi=%h", dout4, last_mosi, e, em);
        end
        repeat (150) @(negedge clk);
        n_vec++;
        if (done_cnt4 - d0 !== 1 || busy4 !== 1'b0) begin
            n_err++; $display("FAIL ignore_single_done got dones=%0d busy=%b exp dones=1 busy=0", done_cnt4 - d0, busy4);
        end
    endtask

    task automatic test_reset_abort;
        bit tmo;
        int d0, r0;
        logic [7:0] e, em;
        slave_prime(8'hF0);
        r0 = rise4;
        go4(8'h99, 1'b0);
        tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise4 - r0 >= 3) begin tmo = 1'b0; break; end
        end
        n_vec++;
        if (tmo) begin n_err++; $display("FAIL abort_wait no 3rd sck rise within 200 cycles"); end
        d0 = done_cnt4;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ss4, sck4, busy4, done4} !== 4'b1000) begin
            n_err++; $display("FAIL abort_async got ss,sck,busy,done=%b exp 1000", {ss4, sck4, busy4, done4});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_cnt4 !== d0 || busy4 !== 1'b0 || dout4 !== 8'h00) begin
            n_err++; $display("FAIL abort_idle got dones=%0d busy=%b dout=%h exp dones=0 busy=0 dout=00", done_cnt4 - d0, busy4, dout4);
        end
        slave_prime(8'hC3);
        exp_q.push_back(8'hC3);  expm_q.push_back(8'h5A);
        go4(8'h5A, 1'b0);
        wait_done4(200, tmo);
        e = exp_q.pop_front(); em = expm_q.pop_front();
        n_vec++;
        if (tmo || cyc - acc_cyc !== 68 || dout4 !== e || last_mosi !== em) begin
            n_err++; $display("FAIL abort_recover got tmo=%b lat=%0d dout=%h mosi=%h exp tmo=0 lat=68 dout=%h mosi=%h",
                              tmo, cyc - acc_cyc, dout4, last_mosi, e, em);
        end
        @(negedge clk);
    endtask

    task automatic test_div255;
        bit   tmo;
        int   a, t_first, t_second;
        logic prev;
        logic [7:0] e;
        start9 = 1'b1; din9 = 8'h96; hold9 = 1'b0;
        exp_q.push_back(8'h96);
        @(negedge clk);
        a = cyc; start9 = 1'b0; din9 = 8'h00;
        prev = sck9; t_first = -1; t_second = -1;
        tmo = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (sck9 !== prev) begin
                if (t_first < 0) t_first = cyc;
                else if (t_second < 0) t_second = cyc;
            end
            prev = sck9;
            if (done9) begin tmo = 1'b0; break; end
        end
        e = exp_q.pop_front();
        n_vec++;
        if (tmo || cyc - a !== 4335) begin
            n_err++; $display("FAIL div255_latency got tmo=%b lat=%0d exp tmo=0 lat=4335", tmo, cyc - a);
        end
        n_vec++;
        if (t_second - t_first !== 255) begin
            n_err++; $display("FAIL div255_half_period got %0d exp 255", t_second - t_first);
        end
        n_vec++;
        if (dout9 !== e || ss9 !== 1'b1) begin
            n_err++; $display("FAIL div255_end got dout=%h ss=%b exp dout=%h ss=1", dout9, ss9, e);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_div2();
        test_slave_model();
        test_back_to_back();
        test_ignore_busy_start();
        test_reset_abort();
        test_div255();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
